// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants and state type for the Ethernet receive FCS checker
package eth_pkg;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [3:0]  PRE_NIB     = 4'h5;
    localparam logic [3:0]  SFD_NIB     = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP,
        ST_EOF
    } rx_state_t;

endpackage

// File: rtl/crc32_d4_calc.sv
// rtl/crc32_d4_calc.sv - CRC-32 register advanced one MII nibble per enabled clock
module crc32_d4_calc
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    // MSB-first register; nibble bit 0 is the first bit on the wire
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 4; i++) begin
            if (crc_next[31] ^ d[i]) begin
                crc_next = {crc_next[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_next = {crc_next[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// rtl/eth_rx_fcs_check.sv - MII receive framer with FCS strip, CRC residue and length checks
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int MIN_PRE = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [3:0]  rxd,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_vld,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_ok,
    output logic        rx_crc_err,
    output logic        rx_len_err,
    output logic        rx_align_err,
    output logic [10:0] rx_len
);

    rx_state_t   state_q, state_d;
    logic        dv_q;
    logic [7:0]  pre_cnt;
    logic        crc_init, crc_en;
    logic [31:0] crc;
    logic        phase;
    logic [3:0]  low_nib;
    logic [7:0]  dly [4];
    logic [2:0]  fill;
    logic [10:0] len_q;
    logic        er_seen, first_pend;
    logic        crc_bad, len_bad;

    crc32_d4_calc u_crc (
        .clk  (clk),
        .rst_n(rst_n),
        .init (crc_init),
        .en   (crc_en),
        .d    (rxd),
        .crc  (crc)
    );

    // A preamble is only accepted on a fresh rx_dv rising edge; dv_q resets high
    // so a frame already in flight at reset release is ignored.
    always_comb begin
        state_d  = state_q;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv && !dv_q && rxd == PRE_NIB) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end else if (rxd == PRE_NIB) begin
                    state_d = ST_PRE;
                end else if (rxd == SFD_NIB && int'(pre_cnt) >= MIN_PRE) begin
                    state_d  = ST_DATA;
                    crc_init = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (rx_dv) crc_en = 1'b1;
                else       state_d = ST_EOF;
            end
            ST_DROP: begin
                if (!rx_dv) state_d = ST_IDLE;
            end
            ST_EOF:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q        <= 1'b1;
            pre_cnt     <= '0;
            phase       <= 1'b0;
            low_nib     <= '0;
            dly         <= '{default: '0};
            fill        <= '0;
            len_q       <= '0;
            er_seen     <= 1'b0;
            first_pend  <= 1'b0;
            rx_byte     <= '0;
            rx_byte_vld <= 1'b0;
            rx_sof      <= 1'b0;
        end else begin
            dv_q        <= rx_dv;
            rx_byte_vld <= 1'b0;
            rx_sof      <= 1'b0;
            if (state_q == ST_IDLE) begin
                pre_cnt <= 8'd1;
            end else if (state_q == ST_PRE && rxd == PRE_NIB && pre_cnt != 8'hFF) begin
                pre_cnt <= pre_cnt + 8'd1;
            end
            if (crc_init) begin
                phase      <= 1'b0;
                fill       <= '0;
                len_q      <= '0;
                er_seen    <= 1'b0;
                first_pend <= 1'b1;
            end
            if (crc_en) begin
                er_seen <= er_seen | rx_er;
                phase   <= ~phase;
                if (!phase) begin
                    low_nib <= rxd;
                end else begin
                    dly[0] <= {rxd, low_nib};
                    dly[1] <= dly[0];
                    dly[2] <= dly[1];
                    dly[3] <= dly[2];
                    if (len_q != 11'h7FF) len_q <= len_q + 11'd1;
                    // Four bytes held back so the FCS never leaves the block
                    if (fill == 3'd4) begin
                        rx_byte     <= dly[3];
                        rx_byte_vld <= 1'b1;
                        rx_sof      <= first_pend;
                        first_pend  <= 1'b0;
                    end else begin
                        fill <= fill + 3'd1;
                    end
                end
            end
        end
    end

    assign crc_bad      = (crc != CRC_RESIDUE) || er_seen;
    assign len_bad      = (int'(len_q) < MIN_LEN) || (int'(len_q) > MAX_LEN);
    assign rx_eof       = (state_q == ST_EOF);
    assign rx_crc_err   = rx_eof && crc_bad;
    assign rx_len_err   = rx_eof && len_bad;
    assign rx_align_err = rx_eof && phase;
    assign rx_ok        = rx_eof && !(crc_bad || len_bad || phase);
    assign rx_len       = len_q;

endmodule
